// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: one STAGE_W-bit slice resolved per stage,
// carry registered between stages, valid/ready handshake with a global stall.
module pipelined_addsub #(
    parameter int WIDTH   = 32,
    parameter int STAGE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int STAGES = WIDTH / STAGE_W;

    logic advance_s;
    logic ovf_r;

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W = WIDTH - k * STAGE_W;
        localparam int LO_W = (k + 1) * STAGE_W;

        logic              v_in_s;
        logic              c_in_s;
        logic [IN_W-1:0]   a_in_s;
        logic [IN_W-1:0]   b_in_s;
        logic [LO_W-1:0]   sum_nx_s;
        logic [STAGE_W:0]  slice_s;
        logic              v_r;
        logic              c_r;
        logic [LO_W-1:0]   sum_r;

        // Operands still to be resolved shrink by one slice per stage; resolved bits grow.
        if (k == 0) begin : g_src
            assign v_in_s   = in_valid;
            assign c_in_s   = cin;
            assign a_in_s   = a;
            assign b_in_s   = b ^ {WIDTH{sub}};
            assign sum_nx_s = slice_s[STAGE_W-1:0];
        end else begin : g_src
            assign v_in_s   = g_stage[k-1].v_r;
            assign c_in_s   = g_stage[k-1].c_r;
            assign a_in_s   = g_stage[k-1].g_fwd.a_r;
            assign b_in_s   = g_stage[k-1].g_fwd.b_r;
            assign sum_nx_s = {slice_s[STAGE_W-1:0], g_stage[k-1].sum_r};
        end

        assign slice_s = {1'b0, a_in_s[STAGE_W-1:0]}
                       + {1'b0, b_in_s[STAGE_W-1:0]}
                       + {{STAGE_W{1'b0}}, c_in_s};

        // Stage register: shifts on advance; data only loads for valid slots so outputs hold on bubbles
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r   <= 1'b0;
                c_r   <= 1'b0;
                sum_r <= {LO_W{1'b0}};
            end else if (advance_s) begin
                v_r <= v_in_s;
                if (v_in_s) begin
                    c_r   <= slice_s[STAGE_W];
                    sum_r <= sum_nx_s;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IN_W-STAGE_W-1:0] a_r;
            logic [IN_W-STAGE_W-1:0] b_r;

            // Unresolved upper operand slices travel with their transaction
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= {(IN_W-STAGE_W){1'b0}};
                    b_r <= {(IN_W-STAGE_W){1'b0}};
                end else if (advance_s && v_in_s) begin
                    a_r <= a_in_s[IN_W-1:STAGE_W];
                    b_r <= b_in_s[IN_W-1:STAGE_W];
                end
            end
        end
    end

    // Signed overflow is decided where the operand sign bits and result sign bit meet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (advance_s && g_stage[STAGES-1].v_in_s) begin
            ovf_r <= (g_stage[STAGES-1].a_in_s[STAGE_W-1] == g_stage[STAGES-1].b_in_s[STAGE_W-1])
                  && (g_stage[STAGES-1].slice_s[STAGE_W-1] != g_stage[STAGES-1].a_in_s[STAGE_W-1]);
        end
    end

    assign out_valid = g_stage[STAGES-1].v_r;
    assign sum       = g_stage[STAGES-1].sum_r;
    assign co        = g_stage[STAGES-1].c_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: three instances (4, 1 and 8 stages) fed the same
// accepted transactions, each checked in order against an arithmetic reference model.
module tb_pipelined_addsub;

    typedef struct packed {
        logic [31:0] sum;
        logic        co;
        logic        ovf;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        in_valid_x;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [31:0] sum0, sum1, sum2;
    logic        co0, co1, co2;
    logic        ovf0, ovf1, ovf2;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   wr_ptr = 0;
    int   rd_ptr [3];
    res_t exp_mem [0:1023];

    logic ov [3];
    logic ordy [3];
    res_t got [3];

    assign in_valid_x = in_valid && in_ready0;

    pipelined_addsub #(.WIDTH(32), .STAGE_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid0), .out_ready(out_ready),
        .sum(sum0), .co(co0), .ovf(ovf0)
    );

    pipelined_addsub #(.WIDTH(32), .STAGE_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(1'b1),
        .sum(sum1), .co(co1), .ovf(ovf1)
    );

    pipelined_addsub #(.WIDTH(32), .STAGE_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready2),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid2), .out_ready(1'b1),
        .sum(sum2), .co(co2), .ovf(ovf2)
    );

    assign ov[0]   = out_valid0;
    assign ov[1]   = out_valid1;
    assign ov[2]   = out_valid2;
    assign ordy[0] = out_ready;
    assign ordy[1] = 1'b1;
    assign ordy[2] = 1'b1;
    assign got[0]  = {sum0, co0, ovf0};
    assign got[1]  = {sum1, co1, ovf1};
    assign got[2]  = {sum2, co2, ovf2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reference: plain 64-bit arithmetic; overflow as "true signed result out of 32-bit range"
    function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mc, input logic ms);
        res_t            r;
        logic [31:0]     beff;
        longint unsigned tot;
        longint          sa;
        longint          sb;
        longint          st;
        beff  = ms ? ~mb : mb;
        tot   = longint'({32'd0, ma}) + longint'({32'd0, beff}) + (mc ? 64'd1 : 64'd0);
        r.sum = tot[31:0];
        r.co  = tot[32];
        sa    = $signed(ma);
        sb    = $signed(beff);
        st    = sa + sb + (mc ? 64'sd1 : 64'sd0);
        r.ovf = (st > 64'sd2147483647) || (st < -64'sd2147483648);
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h7FFF_FFFF;
            3:       v = 32'h8000_0000;
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Monitor / scoreboard
    initial begin
        res_t prev;
        logic prev_stall;
        prev       = '0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) rd_ptr[i] = wr_ptr;
                prev_stall = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (ov[i] && ordy[i]) begin
                        checks++;
                        if (rd_ptr[i] == wr_ptr) begin
                            errors++;
                            $display("FAIL unexpected_result dut%0d: got sum=%h co=%b ovf=%b, expected no output",
                                     i, got[i].sum, got[i].co, got[i].ovf);
                        end else begin
                            if (got[i] !== exp_mem[rd_ptr[i] % 1024]) begin
                                errors++;
                                $display("FAIL result dut%0d #%0d: got sum=%h co=%b ovf=%b, expected sum=%h co=%b ovf=%b",
                                         i, rd_ptr[i], got[i].sum, got[i].co, got[i].ovf,
                                         exp_mem[rd_ptr[i] % 1024].sum, exp_mem[rd_ptr[i] % 1024].co,
                                         exp_mem[rd_ptr[i] % 1024].ovf);
                            end
                            rd_ptr[i]++;
                        end
                    end
                end
                if (prev_stall) begin
                    checks++;
                    if (!ov[0] || got[0] !== prev) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%b sum=%h co=%b ovf=%b, expected valid=1 sum=%h co=%b ovf=%b",
                                 ov[0], got[0].sum, got[0].co, got[0].ovf, prev.sum, prev.co, prev.ovf);
                    end
                end
                if (ov[0] && !ordy[0]) begin
                    checks++;
                    if (in_ready0 !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_in_ready: got %b, expected 0", in_ready0);
                    end
                end
                prev_stall = ov[0] && !ordy[0];
                prev       = got[0];
                if (in_valid && in_ready0) begin
                    exp_mem[wr_ptr % 1024] = model(a, b, cin, sub);
                    wr_ptr++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tbv, input logic tc, input logic ts);
        logic ok;
        int   n;
        ok       = 1'b0;
        n        = 0;
        a        = ta;
        b        = tbv;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready0;
            if (ok) acc_cyc = cyc;
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
        end
    endtask

    task automatic send_rnd();
        send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int lat [3];
        int lat_exp [3];
        logic drained;
        lat_exp[0] = 4;
        lat_exp[1] = 1;
        lat_exp[2] = 8;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'h0;
        b         = 32'h0;
        cin       = 1'b0;
        sub       = 1'b0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || got[i] !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got valid=%b sum=%h co=%b ovf=%b, expected all 0",
                         i, ov[i], got[i].sum, got[i].co, got[i].ovf);
            end
        end
        checks++;
        if (in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // carry ripple across every slice, and latency from an empty pipe
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) lat[i] = -1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (ov[i] && lat[i] < 0) lat[i] = cyc - acc_cyc;
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat[i] != lat_exp[i]) begin
                errors++;
                $display("FAIL latency dut%0d: got %0d cycles, expected %0d", i, lat[i], lat_exp[i]);
            end
        end
        @(posedge clk);
        #1;

        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);

        for (int n = 0; n < 16; n++) send_rnd();

        // fixed 5-cycle backpressure window in the middle of a stream
        fork
            begin
                for (int n = 0; n < 12; n++) send_rnd();
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join

        // random backpressure
        fork
            begin
                for (int n = 0; n < 30; n++) send_rnd();
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;

        // reset with transactions in flight
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        send(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0);
        send(32'h5555_5555, 32'h6666_6666, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || got[i].sum !== 32'h0) begin
                errors++;
                $display("FAIL reset_flush dut%0d: got valid=%b sum=%h, expected valid=0 sum=00000000",
                         i, ov[i], got[i].sum);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready: got %b, expected 1", in_ready0);
        end
        @(posedge clk);
        #1;
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) send_rnd();

        drained = 1'b0;
        for (int n = 0; n < 100 && !drained; n++) begin
            @(negedge clk);
            drained = (rd_ptr[0] == wr_ptr) && (rd_ptr[1] == wr_ptr) && (rd_ptr[2] == wr_ptr);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_ptr[i] != wr_ptr) begin
                errors++;
                $display("FAIL drain dut%0d: got %0d results, expected %0d", i, rd_ptr[i], wr_ptr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
